// File: rtl/sc_regbus_pkg.sv
// Shared definitions for the register-bus arbiter slice.
// Holds the default parameter values and the transfer-sequencer state encoding.
package sc_regbus_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_NUM_REG      = 8;
  localparam int DEF_REGSEL_WIDTH = 3;

  // One transfer walks IDLE -> READ -> WRITE -> DONE -> IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } busState_t;

endpackage

// File: rtl/sc_rr_arbiter.sv
// Combinational round-robin pick.
// Starting at the priority pointer and wrapping at NUM_REQ, returns the index
// of the first requester with its request bit set.
// Ports:
//   reqVec  in   NUM_REQ  request vector
//   ptr     in   PTR_W    priority pointer (index checked first)
//   winner  out  PTR_W    index of the winning requester (0 when none)
//   anyReq  out  1        at least one request bit is set
module sc_rr_arbiter
  import sc_regbus_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               anyReq
);

  // One spare bit so ptr + offset never overflows before the wrap.
  logic [PTR_W:0] slot;

  // Walk the offsets from the farthest to the nearest; the nearest requester
  // from the pointer is the last one written and therefore wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    winner = '0;
    anyReq = 1'b0;
    slot   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      slot = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (slot >= (PTR_W + 1)'(NUM_REQ)) begin
        slot = slot - (PTR_W + 1)'(NUM_REQ);
      end
      if (reqVec[slot[PTR_W-1:0]]) begin
        winner = slot[PTR_W-1:0];
        anyReq = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_regbus_arbiter.sv
// Round-robin arbiter and transfer sequencer for the shared register data bus.
// Grants one requester at a time, drives the bus source-select mux, then
// pulses the destination register's active-low load enable. Every transfer
// costs a fixed four cycles; all outputs are registered one cycle behind the
// sequencer state.
// Ports:
//   SC_RegBusArb_CLOCK_50     in   1                     system clock
//   SC_RegBusArb_Reset_InLow  in   1                     async active-low reset
//   SC_RegBusArb_Req_InHigh   in   NUM_REQ               level requests
//   SC_RegBusArb_Src_In       in   NUM_REQ*REGSEL_WIDTH  packed source indices
//   SC_RegBusArb_Dst_In       in   NUM_REQ*REGSEL_WIDTH  packed destination indices
//   SC_RegBusArb_Grant_Out    out  NUM_REQ               one-hot grant for the transfer
//   SC_RegBusArb_Done_Out     out  NUM_REQ               one-cycle completion pulse
//   SC_RegBusArb_BusSel_Out   out  REGSEL_WIDTH          bus mux select
//   SC_RegBusArb_Load_OutLow  out  NUM_REG               one-hot active-low load enable
//   SC_RegBusArb_Busy_Out     out  1                     transfer in progress
//   SC_RegBusArb_Err_Out      out  1                     out-of-range index pulse
module sc_regbus_arbiter
  import sc_regbus_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int NUM_REG      = DEF_NUM_REG,
  parameter int REGSEL_WIDTH = DEF_REGSEL_WIDTH
) (
  input  logic                            SC_RegBusArb_CLOCK_50,
  input  logic                            SC_RegBusArb_Reset_InLow,
  input  logic [NUM_REQ-1:0]              SC_RegBusArb_Req_InHigh,
  input  logic [NUM_REQ*REGSEL_WIDTH-1:0] SC_RegBusArb_Src_In,
  input  logic [NUM_REQ*REGSEL_WIDTH-1:0] SC_RegBusArb_Dst_In,
  output logic [NUM_REQ-1:0]              SC_RegBusArb_Grant_Out,
  output logic [NUM_REQ-1:0]              SC_RegBusArb_Done_Out,
  output logic [REGSEL_WIDTH-1:0]         SC_RegBusArb_BusSel_Out,
  output logic [NUM_REG-1:0]              SC_RegBusArb_Load_OutLow,
  output logic                            SC_RegBusArb_Busy_Out,
  output logic                            SC_RegBusArb_Err_Out
);

  localparam int PTR_W = $clog2(NUM_REQ);

  busState_t               state, stateNext;
  logic [PTR_W-1:0]        ptr, ptrNext;
  logic [PTR_W-1:0]        pickWinner;
  logic                    pickAny;
  logic [PTR_W-1:0]        winnerQ, winnerNext;
  logic [REGSEL_WIDTH-1:0] srcQ, srcNext;
  logic [REGSEL_WIDTH-1:0] dstQ, dstNext;
  logic [NUM_REQ-1:0]      winnerOneHot;
  logic                    inRange;

  logic [NUM_REQ-1:0]      grantNext, doneNext;
  logic [REGSEL_WIDTH-1:0] busSelNext;
  logic [NUM_REG-1:0]      loadNext;
  logic                    busyNext, errNext;

  sc_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .reqVec (SC_RegBusArb_Req_InHigh),
    .ptr    (ptr),
    .winner (pickWinner),
    .anyReq (pickAny)
  );

  // Both captured indices must address a real register; the extra bit keeps
  // the compare correct when NUM_REG == 2**REGSEL_WIDTH.
  assign inRange = ({1'b0, srcQ} < (REGSEL_WIDTH + 1)'(NUM_REG)) &&
                   ({1'b0, dstQ} < (REGSEL_WIDTH + 1)'(NUM_REG));

  always_comb begin
    winnerOneHot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winnerQ == PTR_W'(i)) winnerOneHot[i] = 1'b1;
    end
  end

  // Next state, captures, pointer and the next value of every output register.
  always_comb begin
    stateNext  = state;
    ptrNext    = ptr;
    winnerNext = winnerQ;
    srcNext    = srcQ;
    dstNext    = dstQ;
    grantNext  = '0;
    doneNext   = '0;
    busSelNext = SC_RegBusArb_BusSel_Out;
    loadNext   = '1;
    busyNext   = 1'b1;
    errNext    = 1'b0;

    case (state)
      IDLE: begin
        busyNext = 1'b0;
        if (pickAny) begin
          // Src/Dst are frozen here; the transfer ignores later input changes.
          winnerNext = pickWinner;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pickWinner == PTR_W'(i)) begin
              srcNext = SC_RegBusArb_Src_In[i*REGSEL_WIDTH +: REGSEL_WIDTH];
              dstNext = SC_RegBusArb_Dst_In[i*REGSEL_WIDTH +: REGSEL_WIDTH];
            end
          end
          stateNext = READ;
        end
      end
      READ: begin
        grantNext  = winnerOneHot;
        busSelNext = srcQ;
        stateNext  = WRITE;
      end
      WRITE: begin
        grantNext  = winnerOneHot;
        busSelNext = srcQ;
        for (int r = 0; r < NUM_REG; r++) begin
          if (inRange && (dstQ == REGSEL_WIDTH'(r))) loadNext[r] = 1'b0;
        end
        stateNext = DONE;
      end
      DONE: begin
        doneNext  = winnerOneHot;
        errNext   = !inRange;
        ptrNext   = (winnerQ == PTR_W'(NUM_REQ - 1)) ? '0 : winnerQ + PTR_W'(1);
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge SC_RegBusArb_CLOCK_50 or negedge SC_RegBusArb_Reset_InLow) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!SC_RegBusArb_Reset_InLow) begin
      state                    <= IDLE;
      ptr                      <= '0;
      winnerQ                  <= '0;
      srcQ                     <= '0;
      dstQ                     <= '0;
      SC_RegBusArb_Grant_Out   <= '0;
      SC_RegBusArb_Done_Out    <= '0;
      SC_RegBusArb_BusSel_Out  <= '0;
      SC_RegBusArb_Load_OutLow <= '1;
      SC_RegBusArb_Busy_Out    <= 1'b0;
      SC_RegBusArb_Err_Out     <= 1'b0;
    end else begin
      state                    <= stateNext;
      ptr                      <= ptrNext;
      winnerQ                  <= winnerNext;
      srcQ                     <= srcNext;
      dstQ                     <= dstNext;
      SC_RegBusArb_Grant_Out   <= grantNext;
      SC_RegBusArb_Done_Out    <= doneNext;
      SC_RegBusArb_BusSel_Out  <= busSelNext;
      SC_RegBusArb_Load_OutLow <= loadNext;
      SC_RegBusArb_Busy_Out    <= busyNext;
      SC_RegBusArb_Err_Out     <= errNext;
    end
  end

endmodule

// File: tb/tb_sc_regbus_arbiter.sv
// Self-checking bench for sc_regbus_arbiter. Two instances share stimulus:
// dut_a has 8 registers, dut_b has 6 so indices 6 and 7 are out of range.
// The reference model is a transaction scheduler: when the bus is free and a
// request is present it picks the round-robin winner and queues the expected
// output pattern for the following three cycles.
module tb_sc_regbus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] src, dst;

  logic [3:0]  gA, dA, gB, dB;
  logic [2:0]  selA, selB;
  logic [7:0]  loadA;
  logic [5:0]  loadB;
  logic        busyA, busyB, errA, errB;

  sc_regbus_arbiter #(.NUM_REQ(4), .NUM_REG(8), .REGSEL_WIDTH(3)) dut_a (
    .SC_RegBusArb_CLOCK_50    (clk),
    .SC_RegBusArb_Reset_InLow (rst_n),
    .SC_RegBusArb_Req_InHigh  (req),
    .SC_RegBusArb_Src_In      (src),
    .SC_RegBusArb_Dst_In      (dst),
    .SC_RegBusArb_Grant_Out   (gA),
    .SC_RegBusArb_Done_Out    (dA),
    .SC_RegBusArb_BusSel_Out  (selA),
    .SC_RegBusArb_Load_OutLow (loadA),
    .SC_RegBusArb_Busy_Out    (busyA),
    .SC_RegBusArb_Err_Out     (errA)
  );

  sc_regbus_arbiter #(.NUM_REQ(4), .NUM_REG(6), .REGSEL_WIDTH(3)) dut_b (
    .SC_RegBusArb_CLOCK_50    (clk),
    .SC_RegBusArb_Reset_InLow (rst_n),
    .SC_RegBusArb_Req_InHigh  (req),
    .SC_RegBusArb_Src_In      (src),
    .SC_RegBusArb_Dst_In      (dst),
    .SC_RegBusArb_Grant_Out   (gB),
    .SC_RegBusArb_Done_Out    (dB),
    .SC_RegBusArb_BusSel_Out  (selB),
    .SC_RegBusArb_Load_OutLow (loadB),
    .SC_RegBusArb_Busy_Out    (busyB),
    .SC_RegBusArb_Err_Out     (errB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] done;
    logic [2:0] sel;
    logic [7:0] loadA;
    logic [5:0] loadB;
    logic       busy;
    logic       errA;
    logic       errB;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   ptr;
  int   tests    = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic [3:0] prevGrant = '0;
  int   gLog[$];
  int   cLog[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t idle_of(input logic [2:0] sel);
    exp_t e;
    e       = '0;
    e.sel   = sel;
    e.loadA = '1;
    e.loadB = '1;
    return e;
  endfunction

  task automatic model_reset();
    expQ.delete();
    ptr = 0;
    cur = idle_of(3'd0);
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    exp_t e;
    int   w, s, d, idx;
    bit   okA, okB;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (expQ.size() != 0) begin
      cur = expQ.pop_front();
      return;
    end
    cur = idle_of(cur.sel);
    w = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (ptr + k) % 4;
      if (w < 0 && ((req >> idx) & 4'd1) != 4'd0) w = idx;
    end
    if (w < 0) return;
    s   = int'((src >> (3 * w)) & 12'h7);
    d   = int'((dst >> (3 * w)) & 12'h7);
    okA = (s < 8) && (d < 8);
    okB = (s < 6) && (d < 6);
    e       = idle_of(3'(s));
    e.grant = 4'(1 << w);
    e.busy  = 1'b1;
    expQ.push_back(e);
    if (okA) e.loadA = ~8'(1 << d);
    if (okB) e.loadB = ~6'(1 << d);
    expQ.push_back(e);
    e.grant = '0;
    e.loadA = '1;
    e.loadB = '1;
    e.done  = 4'(1 << w);
    e.errA  = !okA;
    e.errB  = !okB;
    expQ.push_back(e);
    ptr = (w + 1) % 4;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check("grantA", gA,    cur.grant);
    check("doneA",  dA,    cur.done);
    check("selA",   selA,  cur.sel);
    check("loadA",  loadA, cur.loadA);
    check("busyA",  busyA, cur.busy);
    check("errA",   errA,  cur.errA);
    check("grantB", gB,    cur.grant);
    check("doneB",  dB,    cur.done);
    check("selB",   selB,  cur.sel);
    check("loadB",  loadB, cur.loadB);
    check("busyB",  busyB, cur.busy);
    check("errB",   errB,  cur.errB);
    if (prevGrant == 4'd0 && gA != 4'd0) begin
      gLog.push_back(int'(gA));
      cLog.push_back(cyc);
    end
    prevGrant = gA;
  endtask

  task automatic set_move(input int i, input int s, input int d);
    src[i*3 +: 3] = 3'(s);
    dst[i*3 +: 3] = 3'(d);
  endtask

  initial begin
    req   = '0;
    src   = '0;
    dst   = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();

    // Single move 3 -> 6 by requester 0.
    rst_n = 1'b1;
    set_move(0, 3, 6);
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    check("sm_grant", gA, 4'b0001);
    check("sm_sel", selA, 3'd3);
    step();
    check("sm_load", loadA, 8'hBF);
    step();
    check("sm_done", dA, 4'b0001);
    step();
    check("sm_busy", busyA, 1'b0);

    // Destination 7 is out of range only for the 6-register instance.
    set_move(1, 1, 7);
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    step();
    check("oor_loadB", loadB, 6'h3F);
    check("oor_loadA", loadA, 8'h7F);
    step();
    check("oor_errB", errB, 1'b1);
    check("oor_doneB", dB, 4'b0010);
    check("oor_errA", errA, 1'b0);
    step();

    // Source out of range for dut_b, and a Src == Dst move.
    set_move(2, 6, 2);
    req = 4'b0100;
    step();
    req = 4'b0000;
    repeat (4) step();
    set_move(3, 4, 4);
    req = 4'b1000;
    step();
    req = 4'b0000;
    repeat (4) step();

    // Request withdrawn and source changed while the transfer is in flight.
    set_move(0, 2, 4);
    req = 4'b0001;
    step();
    req = 4'b0000;
    set_move(0, 5, 1);
    step();
    check("wd_sel", selA, 3'd2);
    step();
    check("wd_load", loadA, 8'hEF);
    step();
    check("wd_done", dA, 4'b0001);
    step();

    // Asynchronous reset in the middle of the WRITE cycle.
    set_move(0, 1, 5);
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    step();
    check("mr_load_pre", loadA, 8'hDF);
    #2 rst_n = 1'b0;
    #1;
    check("mr_load", loadA, 8'hFF);
    check("mr_grant", gA, 4'b0000);
    check("mr_busy", busyA, 1'b0);
    check("mr_done", dA, 4'b0000);
    model_reset();
    repeat (2) step();

    // Fairness: all four requesting from reset.
    req = 4'b1111;
    src = 12'(32'h00000531);
    dst = 12'(32'h00000a27);
    step();
    gLog.delete();
    cLog.delete();
    rst_n = 1'b1;
    repeat (22) step();
    check("fair_count", 32'(gLog.size() >= 5), 32'd1);
    if (gLog.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("fair_grant%0d", i), 32'(gLog[i]), 32'(1 << (i % 4)));
        if (i > 0) check($sformatf("fair_gap%0d", i), 32'(cLog[i] - cLog[i-1]), 32'd4);
      end
    end

    // Pointer wrap: after requester 3, requesters 0 and 3 compete.
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    rst_n = 1'b1;
    req   = 4'b1000;
    step();
    req = 4'b0000;
    repeat (4) step();
    gLog.delete();
    cLog.delete();
    req = 4'b1001;
    repeat (9) step();
    check("wrap_count", 32'(gLog.size() >= 2), 32'd1);
    if (gLog.size() >= 2) begin
      check("wrap_first", 32'(gLog[0]), 32'd1);
      check("wrap_second", 32'(gLog[1]), 32'd8);
    end

    // Randomized traffic, including out-of-range indices for dut_b.
    req = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      src = 12'($urandom);
      dst = 12'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/sc_regbus_arbiter.md
# sc_regbus_arbiter

Round-robin arbiter and transfer sequencer for the shared register data bus of the simple-computer datapath. Up to NUM_REQ requesters each ask for one register-to-register move (source index, destination index). The block grants one requester at a time, drives the bus source-select mux, then pulses the destination register's load enable. It sits between the control units and the register file, which contains the fixed and general registers.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_REG, 8, number of registers on the bus
- REGSEL_WIDTH, 3, width of a register index; NUM_REG ≤ 2^REGSEL_WIDTH

Ports:
- SC_RegBusArb_CLOCK_50  in  1  system clock, all state on rising edge
- SC_RegBusArb_Reset_InLow  in  1  **asynchronous, active-low reset**
- SC_RegBusArb_Req_InHigh  in  NUM_REQ  per-requester transfer request, level
- SC_RegBusArb_Src_In  in  NUM_REQ*REGSEL_WIDTH  packed source indices; requester i uses bits [i*REGSEL_WIDTH +: REGSEL_WIDTH]
- SC_RegBusArb_Dst_In  in  NUM_REQ*REGSEL_WIDTH  packed destination indices, same packing
- SC_RegBusArb_Grant_Out  out  NUM_REQ  one-hot grant, held for the whole transfer
- SC_RegBusArb_Done_Out  out  NUM_REQ  one-cycle completion pulse to the granted requester
- SC_RegBusArb_BusSel_Out  out  REGSEL_WIDTH  bus mux select (source register index)
- SC_RegBusArb_Load_OutLow  out  NUM_REG  one-hot, active-low destination load enable
- SC_RegBusArb_Busy_Out  out  1  high in any state other than IDLE
- SC_RegBusArb_Err_Out  out  1  one-cycle pulse on an out-of-range index

## Operation
- Four-state FSM: IDLE → READ → WRITE → DONE → IDLE. All outputs are registered.
- IDLE:
  - If any Req bit is high, pick the winner by round-robin, starting at the priority pointer and wrapping at NUM_REQ.
  - Latch the winner's index, Src and Dst; go to READ.
  - With no requests, stay in IDLE.
- READ:
  - Grant = onehot(winner), BusSel = latched Src, Busy = 1.
  - Load stays all ones. This is the bus-settle cycle.
- WRITE:
  - Grant and BusSel are held.
  - Load_OutLow[Dst] = 0 for exactly this cycle.
- DONE:
  - Done[winner] = 1 and Grant = 0.
  - BusSel keeps its value.
  - Pointer = (winner + 1) mod NUM_REQ.
- Src and Dst are captured once in IDLE. Later changes to the inputs, or Req dropping mid-transfer, do not affect an in-flight transfer; it always completes.
- Src == Dst: the transfer runs normally.
- Src or Dst ≥ NUM_REG: the FSM still walks READ/WRITE/DONE, but no Load bit asserts and Err pulses in DONE together with Done.
- A requester holding Req high after Done is re-arbitrated; it waits behind any other pending requesters because of pointer rotation.
- The block is unaware of which registers are fixed (read-only). Writes to them are harmless because they ignore load.

## Timing
- Reset asserted (async, any state, including mid-transfer):
  - state = IDLE, pointer = 0
  - Grant = 0, Done = 0, BusSel = 0, Load_OutLow = all ones, Busy = 0, Err = 0
  - An interrupted transfer is abandoned with no Done and no Load.
- Reset is released synchronously by the surrounding logic. The first arbitration happens on the first rising edge with reset high.
- Request sampled at edge t (IDLE) → Grant/BusSel valid after t+1 → Load low after t+2 → Done/Err after t+3 → IDLE after t+4.
- Fixed 4-cycle cost per transfer. Back-to-back requests give a new Grant every 4 cycles.
- Simultaneous requests are resolved only in IDLE. A request arriving during a transfer waits for the next IDLE.

## Structure
- Package/include sc_regbus_pkg holds:
  - state encodings (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3)
  - default parameter values
- One sub-module, sc_rr_arbiter:
  - combinational round-robin pick
  - inputs: Req vector and pointer
  - outputs: winner index and any-request flag
- The FSM, capture registers and pointer stay in the top module.

## Test plan
- Reset and idle: Reset_InLow=0 mid-WRITE (Load[5] low) → next sample shows Load = 8'hFF, Grant = 0, Busy = 0; no Done.
- Single move: Req=4'b0001, Src0=3, Dst0=6 → Grant=0001 and BusSel=3 at t+1, Load_OutLow=8'hBF at t+2, Done=0001 at t+3, Busy low at t+4.
- Fairness: Req=4'b1111 held continuously from reset → grant order 0,1,2,3,0, each Grant 4 cycles apart.
- Pointer wrap: after granting requester 3, Req=4'b1001 → requester 0 wins; next grant goes to 3.
- Out-of-range: NUM_REG=6, Dst=7 → no Load bit low during WRITE; Err and Done pulse together at t+3.
- Request withdrawal and input change: Req0 drops and Src0 changes 2→5 during READ → BusSel stays 2, Load still asserts, Done pulses.
